// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite single-port memory slave with programmable data-phase wait states
// and two-cycle ERROR response for out-of-range, oversize or misaligned accesses.
//
// state   | meaning
// IDLE    | no data phase in progress, ready
// WAIT    | legal transfer stalled by the wait-state down-counter
// OKAY    | data phase completes: write commits / read data valid
// ERR1    | first ERROR cycle, HREADYOUT low
// ERR2    | second ERROR cycle, HREADYOUT high
module ahb_lite_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH * BYTES);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_OKAY, ST_ERR1, ST_ERR2} state_t;

  state_t            state, state_nxt;
  logic [2:0]        wait_cnt;
  logic              accept, take, illegal;
  logic [7:0]        size_bytes;
  logic [OFF_W-1:0]  off_q;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [BYTES-1:0]  lane_en;
  logic              mem_wr;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_write;
  logic              rd_load;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              unused_bits;

  assign unused_bits = ^{HTRANS[0], HBURST, HPROT};

  assign accept     = HSEL & HREADY & HTRANS[1];
  assign take       = accept && (state != ST_WAIT) && (state != ST_ERR1);
  assign size_bytes = 8'd1 << HSIZE;
  assign illegal    = ({1'b0, HADDR} >= MEM_BYTES) || (size_bytes > 8'(BYTES)) ||
                      (|(HADDR[7:0] & (size_bytes - 8'd1)));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_WAIT: state_nxt = (wait_cnt == 3'd0) ? ST_OKAY : ST_WAIT;
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        if (take) begin
          if (illegal)              state_nxt = ST_ERR1;
          else if (WAIT_STATES > 0) state_nxt = ST_WAIT;
          else                      state_nxt = ST_OKAY;
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin HREADYOUT = 1'b0; HRESP = 1'b1; end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // Loaded with WAIT_STATES-1 so terminal count 0 marks the last WAIT cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      wait_cnt <= 3'd0;
    else if (state_nxt == ST_WAIT && state != ST_WAIT)
      wait_cnt <= 3'(WAIT_STATES - 1);
    else if (state == ST_WAIT && wait_cnt != 3'd0)
      wait_cnt <= wait_cnt - 3'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      off_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else if (take) begin
      off_q   <= HADDR[OFF_W-1:0];
      idx_q   <= HADDR[OFF_W +: IDX_W];
      write_q <= HWRITE;
      size_q  <= HSIZE;
    end
  end

  always_comb begin
    lane_en = '0;
    for (int i = 0; i < BYTES; i++)
      lane_en[i] = (i >= int'(off_q)) && (i < int'(off_q) + (1 << size_q));
  end

  assign mem_wr = (state == ST_OKAY) && write_q;

  always_ff @(posedge HCLK) begin
    if (mem_wr)
      for (int i = 0; i < BYTES; i++)
        if (lane_en[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
  end

  // Read data is registered on entry to OKAY; a write committing on the same
  // edge to the same word is merged in so the read sees post-write data.
  assign rd_idx   = (state == ST_WAIT) ? idx_q : HADDR[OFF_W +: IDX_W];
  assign rd_write = (state == ST_WAIT) ? write_q : HWRITE;
  assign rd_load  = (state_nxt == ST_OKAY) && !rd_write;

  always_comb begin
    rd_word = mem[rd_idx];
    if (mem_wr && (rd_idx == idx_q))
      for (int i = 0; i < BYTES; i++)
        if (lane_en[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     HRDATA <= '0;
    else if (rd_load) HRDATA <= rd_word;
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: one zero-wait instance and one two-wait instance,
// read data checked through expected/observed queues.
module tb_ahb_lite_mem_slave;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad = 0;

  // zero-wait-state instance
  logic        hsel = 0, hwrite = 0;
  logic [1:0]  htrans = 0;
  logic [2:0]  hsize = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [31:0] hrdata;
  logic        hreadyout, hresp;

  // two-wait-state instance
  logic        w_hsel = 0, w_hwrite = 0;
  logic [1:0]  w_htrans = 0;
  logic [2:0]  w_hsize = 0;
  logic [31:0] w_haddr = 0, w_hwdata = 0;
  logic [31:0] w_hrdata;
  logic        w_hreadyout, w_hresp;

  ahb_lite_mem_slave #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011),
    .HREADY(hreadyout), .HWDATA(hwdata), .HRDATA(hrdata), .HREADYOUT(hreadyout),
    .HRESP(hresp));

  ahb_lite_mem_slave #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(w_hsel), .HADDR(w_haddr), .HTRANS(w_htrans),
    .HWRITE(w_hwrite), .HSIZE(w_hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HREADY(w_hreadyout), .HWDATA(w_hwdata), .HRDATA(w_hrdata), .HREADYOUT(w_hreadyout),
    .HRESP(w_hresp));

  logic [31:0] exp_q[$], obs_q[$];
  int          stall_cnt = 0;
  logic        pend_valid = 0, pend_wr = 0;
  logic [31:0] pend_wdata = 0;

  logic [31:0] w_exp_q[$], w_obs_q[$];
  logic        w_rdy_q[$];
  int          w_err_cnt = 0;
  logic        w_timeout = 0;
  logic        w_pend_valid = 0, w_pend_wr = 0;
  logic [31:0] w_pend_wdata = 0;

  // One pipelined cycle on the zero-wait bus; called just after a posedge.
  task automatic drive0(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    hwdata = (pend_valid && pend_wr) ? pend_wdata : 32'h0BAD_0BAD;
    hsel = sel; htrans = trans; haddr = addr; hwrite = wr; hsize = size;
    @(negedge HCLK);
    if (!hreadyout) stall_cnt++;
    if (pend_valid && !pend_wr) obs_q.push_back(hrdata);
    @(posedge HCLK); #1;
    pend_valid = sel & trans[1]; pend_wr = wr; pend_wdata = wdata;
  endtask

  // Presents one address phase on the wait-state bus and holds it until accepted.
  task automatic drive2(input logic sel, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata);
    logic rdy;
    logic done;
    done = 0;
    w_hwdata = (w_pend_valid && w_pend_wr) ? w_pend_wdata : 32'h0BAD_0BAD;
    w_hsel = sel; w_htrans = sel ? 2'b10 : 2'b00; w_haddr = addr; w_hwrite = wr; w_hsize = size;
    for (int n = 0; n < 16; n++) begin
      @(negedge HCLK);
      rdy = w_hreadyout;
      w_rdy_q.push_back(rdy);
      if (w_hresp) w_err_cnt++;
      if (rdy && w_pend_valid && !w_pend_wr) w_obs_q.push_back(w_hrdata);
      @(posedge HCLK); #1;
      if (rdy) begin done = 1; break; end
    end
    if (!done) w_timeout = 1;
    w_pend_valid = sel; w_pend_wr = wr; w_pend_wdata = wdata;
  endtask

  task automatic test_reset();
    HRESETn = 0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL rst_ready0: got %b want 1", hreadyout); end
    total++; if (hresp !== 1'b0) begin bad++; $display("FAIL rst_resp0: got %b want 0", hresp); end
    total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rst_rdata0: got %h want 0", hrdata); end
    total++; if (w_hreadyout !== 1'b1) begin bad++; $display("FAIL rst_ready2: got %b want 1", w_hreadyout); end
    total++; if (w_hresp !== 1'b0) begin bad++; $display("FAIL rst_resp2: got %b want 0", w_hresp); end
    total++; if (w_hrdata !== 32'h0) begin bad++; $display("FAIL rst_rdata2: got %h want 0", w_hrdata); end
    @(posedge HCLK); #1;
    HRESETn = 1;
  endtask

  task automatic test_basic_rw();
    logic [31:0] e, o;
    stall_cnt = 0; obs_q.delete();
    drive0(1, 2'b10, 1, 32'h10, 3'b010, 32'hDEAD_BEEF);
    drive0(1, 2'b10, 0, 32'h10, 3'b010, 32'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    drive0(0, 2'b00, 0, 32'h0, 3'b010, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL basic_read: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL basic_read: got %h want %h", o, e); end
      end
    end
    total++; if (stall_cnt != 0) begin bad++; $display("FAIL basic_stalls: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] e, o;
    stall_cnt = 0; obs_q.delete();
    drive0(1, 2'b10, 1, 32'h10, 3'b010, 32'h1122_3344);
    drive0(1, 2'b10, 1, 32'h14, 3'b010, 32'h5566_7788);
    drive0(1, 2'b10, 1, 32'h13, 3'b000, 32'hAA00_0000);
    drive0(1, 2'b10, 0, 32'h10, 3'b010, 32'h0);
    exp_q.push_back(32'hAA22_3344);
    drive0(1, 2'b10, 1, 32'h16, 3'b001, 32'hCAFE_0000);
    drive0(1, 2'b10, 0, 32'h14, 3'b010, 32'h0);
    exp_q.push_back(32'hCAFE_7788);
    drive0(0, 2'b00, 0, 32'h0, 3'b010, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL lane_read: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL lane_read: got %h want %h", o, e); end
      end
    end
    total++; if (stall_cnt != 0) begin bad++; $display("FAIL lane_stalls: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, o;
    logic [31:0] data [8];
    stall_cnt = 0; obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      data[i] = $urandom;
      drive0(1, 2'b10, 1, 32'h100 + 32'(4 * i), 3'b010, data[i]);
    end
    drive0(0, 2'b10, 1, 32'h100, 3'b010, 32'hFFFF_FFFF);
    drive0(1, 2'b01, 1, 32'h104, 3'b010, 32'hFFFF_FFFF);
    drive0(1, 2'b00, 1, 32'h108, 3'b010, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      drive0(1, 2'b11, 0, 32'h100 + 32'(4 * i), 3'b010, 32'h0);
      exp_q.push_back(data[i]);
    end
    drive0(0, 2'b00, 0, 32'h0, 3'b010, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL b2b_read: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL b2b_read: got %h want %h", o, e); end
      end
    end
    total++; if (stall_cnt != 0) begin bad++; $display("FAIL b2b_stalls: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_errors();
    logic [31:0] e, o;
    logic [31:0] ea [3];
    logic [2:0]  es [3];
    logic        ew [3];
    ea = '{32'h1000, 32'h2, 32'h8};
    es = '{3'b010, 3'b010, 3'b011};
    ew = '{1'b1, 1'b1, 1'b0};
    obs_q.delete();
    drive0(1, 2'b10, 1, 32'h0, 3'b010, 32'hCAFE_F00D);
    drive0(1, 2'b10, 0, 32'h0, 3'b010, 32'h0);
    exp_q.push_back(32'hCAFE_F00D);
    drive0(0, 2'b00, 0, 32'h0, 3'b010, 32'h0);
    for (int k = 0; k < 3; k++) begin
      hsel = 1; htrans = 2'b10; haddr = ea[k]; hwrite = ew[k]; hsize = es[k]; hwdata = 32'h0;
      @(posedge HCLK); #1;
      hsel = 0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
      @(negedge HCLK);
      total++; if ({hreadyout, hresp} !== 2'b01) begin bad++; $display("FAIL err1_%0d: got rdy/resp %b%b want 01", k, hreadyout, hresp); end
      @(posedge HCLK); #1;
      @(negedge HCLK);
      total++; if ({hreadyout, hresp} !== 2'b11) begin bad++; $display("FAIL err2_%0d: got rdy/resp %b%b want 11", k, hreadyout, hresp); end
      total++; if (hrdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL err_rdata_%0d: got %h want cafef00d", k, hrdata); end
      @(posedge HCLK); #1;
      @(negedge HCLK);
      total++; if ({hreadyout, hresp} !== 2'b10) begin bad++; $display("FAIL err_idle_%0d: got rdy/resp %b%b want 10", k, hreadyout, hresp); end
      @(posedge HCLK); #1;
    end
    drive0(1, 2'b10, 0, 32'h0, 3'b010, 32'h0);
    exp_q.push_back(32'hCAFE_F00D);
    drive0(0, 2'b00, 0, 32'h0, 3'b010, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL err_mem: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL err_mem: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] e, o;
    logic [12:0] got;
    w_rdy_q.delete(); w_obs_q.delete(); w_err_cnt = 0; w_timeout = 0;
    drive2(1, 1, 32'h0, 3'b010, 32'h1357_9BDF);
    drive2(1, 0, 32'h0, 3'b010, 32'h0);
    w_exp_q.push_back(32'h1357_9BDF);
    drive2(1, 1, 32'h4, 3'b010, 32'h2468_ACE0);
    drive2(1, 0, 32'h4, 3'b010, 32'h0);
    w_exp_q.push_back(32'h2468_ACE0);
    drive2(0, 0, 32'h0, 3'b010, 32'h0);
    got = '0;
    foreach (w_rdy_q[i]) got = {got[11:0], w_rdy_q[i]};
    total++;
    if (w_rdy_q.size() != 13 || got !== 13'b1_001_001_001_001)
      begin bad++; $display("FAIL ws_ready_pattern: got %b (%0d cycles) want 1001001001001", got, w_rdy_q.size()); end
    total++; if (w_timeout !== 1'b0) begin bad++; $display("FAIL ws_timeout: got %b want 0", w_timeout); end
    total++; if (w_err_cnt != 0) begin bad++; $display("FAIL ws_resp: got %0d error cycles want 0", w_err_cnt); end
    while (w_exp_q.size() != 0) begin
      e = w_exp_q.pop_front(); total++;
      if (w_obs_q.size() == 0) begin bad++; $display("FAIL ws_read: got none want %h", e); end
      else begin
        o = w_obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL ws_read: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] e, o;
    w_obs_q.delete(); obs_q.delete(); w_timeout = 0;
    drive2(1, 1, 32'h20, 3'b010, 32'h1111_1111);
    drive2(0, 0, 32'h0, 3'b010, 32'h0);
    w_hsel = 1; w_htrans = 2'b10; w_haddr = 32'h20; w_hwrite = 1; w_hsize = 3'b010;
    @(posedge HCLK); #1;
    w_hsel = 0; w_htrans = 2'b00; w_hwdata = 32'h0000_0055;
    @(negedge HCLK);
    total++; if (w_hreadyout !== 1'b0) begin bad++; $display("FAIL midwait_ready: got %b want 0", w_hreadyout); end
    #2 HRESETn = 0;
    #1;
    total++; if (w_hreadyout !== 1'b1) begin bad++; $display("FAIL async_rst_ready: got %b want 1", w_hreadyout); end
    total++; if (w_hresp !== 1'b0) begin bad++; $display("FAIL async_rst_resp: got %b want 0", w_hresp); end
    total++; if (w_hrdata !== 32'h0) begin bad++; $display("FAIL async_rst_rdata: got %h want 0", w_hrdata); end
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1;
    w_pend_valid = 0; pend_valid = 0;
    drive2(1, 0, 32'h20, 3'b010, 32'h0);
    w_exp_q.push_back(32'h1111_1111);
    drive2(0, 0, 32'h0, 3'b010, 32'h0);
    drive0(1, 2'b10, 0, 32'h10, 3'b010, 32'h0);
    exp_q.push_back(32'hAA22_3344);
    drive0(0, 2'b00, 0, 32'h0, 3'b010, 32'h0);
    total++; if (w_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", w_timeout); end
    while (w_exp_q.size() != 0) begin
      e = w_exp_q.pop_front(); total++;
      if (w_obs_q.size() == 0) begin bad++; $display("FAIL rst_abort_mem: got none want %h", e); end
      else begin
        o = w_obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL rst_abort_mem: got %h want %h", o, e); end
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rst_keep_mem: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL rst_keep_mem: got %h want %h", o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    test_wait_states();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
